// File: rtl/comm_responder.sv
// comm_responder: copter-side endpoint of the wireless command link.
//
// Receives 3-byte command frames (opcode, data high, data low) on RX and
// presents them as cmd/data with a cmd_rdy flag. Transmits a single response
// byte on TX when send_resp is strobed. RX and TX are fully independent.
//
// Parameters:
//   BAUD_DIV      clocks per UART bit
//   TIMEOUT_BAUDS inter-byte gap, in bit times, that aborts a partial frame
//
// Ports:
//   clk, rst_n     system clock (rising edge), async active-low reset
//   RX / TX        serial lines, both idle high
//   cmd, data      opcode and {byte1, byte2} of the last complete frame
//   cmd_rdy        a complete frame is held; cleared by clr_cmd_rdy or by
//                  the first byte of a new frame (a simultaneous set wins)
//   resp           response byte, latched when send_resp is seen in TX idle
//   send_resp      one-cycle strobe starting a response transmission
//   resp_sent      level; the last response has fully left TX
//
// Build option:
//   FRAME_TIMEOUT_EN  when defined, a partial frame is abandoned after
//                     TIMEOUT_BAUDS bit times without a new start bit.
//
// State summary
//   RX_IDLE  | waiting for a falling edge on the synchronized RX line
//   RX_RECV  | sampling start, 8 data bits and stop at mid-bit
//   F_IDLE   | no partial frame; next good byte is the opcode
//   F_HAVE1  | opcode buffered; next byte is data high
//   F_HAVE2  | opcode and data high buffered; next byte completes the frame
//   TX_IDLE  | TX held high, waiting for send_resp
//   TX_XMIT  | shifting start, 8 data bits LSB first, stop

module comm_responder #(
    parameter int BAUD_DIV      = 2604,
    parameter int TIMEOUT_BAUDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam int                BAUD_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 2;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    // The falling edge is recognised two clocks after it happens (synchronizer),
    // so the half-bit wait is shortened to land the start sample at BAUD_DIV/2.
    localparam logic [BAUD_W-1:0] HALF_LOAD = BAUD_W'(BAUD_DIV / 2 - 2);

    if (BAUD_DIV < 4 || TIMEOUT_BAUDS < 1) begin : g_bad_cfg
        $error("comm_responder: BAUD_DIV must be >= 4 and TIMEOUT_BAUDS >= 1");
    end

    // ------------------------------------------------------------------
    // RX synchronizer plus one delay flop for falling-edge detection
    // ------------------------------------------------------------------
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ------------------------------------------------------------------
    // RX byte engine
    // ------------------------------------------------------------------
    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;

    rx_state_t         rx_state, rx_next;
    logic [BAUD_W-1:0] rx_baud;
    logic [3:0]        rx_bit;
    logic [7:0]        rx_shift;
    logic              rx_start, byte_valid, byte_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next    = rx_state;
        rx_start   = 1'b0;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_start = 1'b1;
                    rx_next  = RX_RECV;
                end
            end
            RX_RECV: begin
                if (rx_baud == '0) begin
                    if (rx_bit == 4'd0 && rx_sync) begin
                        rx_next = RX_IDLE;          // start bit was a glitch
                    end else if (rx_bit == 4'd9) begin
                        rx_next    = RX_IDLE;
                        byte_valid = rx_sync;
                        byte_err   = !rx_sync;
                    end
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_baud  <= '0;
            rx_bit   <= 4'd0;
            rx_shift <= 8'h00;
        end else if (rx_start) begin
            rx_baud <= HALF_LOAD;
            rx_bit  <= 4'd0;
        end else if (rx_state == RX_RECV) begin
            if (rx_baud == '0) begin
                rx_baud <= BAUD_LAST;
                rx_bit  <= (rx_next == RX_IDLE) ? 4'd0 : rx_bit + 4'd1;
                if (rx_bit >= 4'd1 && rx_bit <= 4'd8)
                    rx_shift <= {rx_sync, rx_shift[7:1]};
            end else begin
                rx_baud <= rx_baud - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame assembler
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {F_IDLE, F_HAVE1, F_HAVE2} frame_state_t;

    frame_state_t f_state, f_next;
    logic         load_op, load_hi, complete, gap_expired;
    logic [7:0]   op_buf, hi_buf;

`ifdef FRAME_TIMEOUT_EN
    localparam int               GAP_CLKS = TIMEOUT_BAUDS * BAUD_DIV;
    localparam int               GAP_W    = $clog2(GAP_CLKS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

    logic [GAP_W-1:0] gap_cnt;
    logic             gap_run;

    // Only idle line time between bytes of a partial frame is counted.
    assign gap_run     = (f_state != F_IDLE) && (rx_state == RX_IDLE) && !rx_start;
    assign gap_expired = gap_run && (gap_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            gap_cnt <= '0;
        else if (rx_start || f_state == F_IDLE)
            gap_cnt <= GAP_LAST;
        else if (gap_run && gap_cnt != '0)
            gap_cnt <= gap_cnt - 1'b1;
    end
`else
    assign gap_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) f_state <= F_IDLE;
        else        f_state <= f_next;
    end

    always_comb begin
        f_next   = f_state;
        load_op  = 1'b0;
        load_hi  = 1'b0;
        complete = 1'b0;
        if (byte_err) begin
            f_next = F_IDLE;
        end else if (byte_valid) begin
            case (f_state)
                F_IDLE:  begin load_op  = 1'b1; f_next = F_HAVE1; end
                F_HAVE1: begin load_hi  = 1'b1; f_next = F_HAVE2; end
                F_HAVE2: begin complete = 1'b1; f_next = F_IDLE;  end
                default: f_next = F_IDLE;
            endcase
        end else if (gap_expired) begin
            f_next = F_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_buf  <= 8'h00;
            hi_buf  <= 8'h00;
            cmd     <= 8'h00;
            data    <= 16'h0000;
            cmd_rdy <= 1'b0;
        end else begin
            if (load_op) op_buf <= rx_shift;
            if (load_hi) hi_buf <= rx_shift;
            if (complete) begin
                cmd  <= op_buf;
                data <= {hi_buf, rx_shift};
            end
            if (complete)
                cmd_rdy <= 1'b1;
            else if (clr_cmd_rdy || load_op)
                cmd_rdy <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // TX engine
    // ------------------------------------------------------------------
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

    tx_state_t         tx_state, tx_next;
    logic [BAUD_W-1:0] tx_baud;
    logic [3:0]        tx_bit;
    logic [8:0]        tx_sr;       // {stop, data}; start bit is driven on load
    logic              tx_load, tx_adv, tx_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        tx_adv  = 1'b0;
        tx_done = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_load = 1'b1;
                    tx_next = TX_XMIT;
                end
            end
            TX_XMIT: begin
                if (tx_baud == '0) begin
                    if (tx_bit == 4'd9) begin
                        tx_done = 1'b1;
                        tx_next = TX_IDLE;
                    end else begin
                        tx_adv = 1'b1;
                    end
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            TX        <= 1'b1;
            tx_baud   <= '0;
            tx_bit    <= 4'd0;
            tx_sr     <= 9'h1FF;
            resp_sent <= 1'b0;
        end else if (tx_load) begin
            TX        <= 1'b0;
            tx_sr     <= {1'b1, resp};
            tx_baud   <= BAUD_LAST;
            tx_bit    <= 4'd0;
            resp_sent <= 1'b0;
        end else if (tx_adv) begin
            TX      <= tx_sr[0];
            tx_sr   <= {1'b1, tx_sr[8:1]};
            tx_baud <= BAUD_LAST;
            tx_bit  <= tx_bit + 4'd1;
        end else if (tx_done) begin
            TX        <= 1'b1;
            tx_bit    <= 4'd0;
            resp_sent <= 1'b1;
        end else if (tx_state == TX_XMIT) begin
            tx_baud <= tx_baud - 1'b1;
        end
    end

endmodule

// File: tb/tb_comm_responder.sv
module tb_comm_responder;

    localparam int B  = 16;
    localparam int TB = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        tx;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;

    int total = 0;
    int bad   = 0;
    int rises = 0;
    logic rdy_q = 1'b0;

    comm_responder #(.BAUD_DIV(B), .TIMEOUT_BAUDS(TB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (rx),
        .TX          (tx),
        .cmd         (cmd),
        .data        (data),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_rdy && !rdy_q) rises <= rises + 1;
        rdy_q <= cmd_rdy;
    end

    typedef struct {
        logic [7:0]  b0, b1, b2;
        logic [7:0]  e_cmd;
        logic [15:0] e_data;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (B) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int         pos;
        int         target;
        int         r0;
        logic [9:0] exp_bits;

        vecs[0] = '{8'h05, 8'h01, 8'hFF, 8'h05, 16'h01FF};
        vecs[1] = '{8'hA5, 8'h5A, 8'hC3, 8'hA5, 16'h5AC3};
        vecs[2] = '{8'h00, 8'h80, 8'h01, 8'h00, 16'h8001};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'hFFFF};
        vecs[4] = '{8'h3C, 8'h00, 8'h00, 8'h3C, 16'h0000};

        rst_n = 1'b0; rx = 1'b1; clr_cmd_rdy = 1'b0; resp = 8'h00; send_resp = 1'b0;
        idle_cycles(5);
        rst_n = 1'b1;
        idle_cycles(2);

        check("reset_tx",        32'(tx),        32'h1);
        check("reset_cmd_rdy",   32'(cmd_rdy),   32'h0);
        check("reset_resp_sent", 32'(resp_sent), 32'h0);
        check("reset_cmd",       32'(cmd),       32'h00);
        check("reset_data",      32'(data),      32'h0000);

        idle_cycles(30 * B);
        check("idle_cmd_rdy", 32'(cmd_rdy), 32'h0);
        check("idle_cmd",     32'(cmd),     32'h00);
        check("idle_data",    32'(data),    32'h0000);

        // Table-driven frames: receive, check, acknowledge, check held values
        for (int v = 0; v < 5; v++) begin
            send_byte(vecs[v].b0, 1'b1);
            send_byte(vecs[v].b1, 1'b1);
            send_byte(vecs[v].b2, 1'b1);
            idle_cycles(2 * B);
            check($sformatf("vec%0d_cmd", v),     32'(cmd),     32'(vecs[v].e_cmd));
            check($sformatf("vec%0d_data", v),    32'(data),    32'(vecs[v].e_data));
            check($sformatf("vec%0d_cmd_rdy", v), 32'(cmd_rdy), 32'h1);
            clr_cmd_rdy = 1'b1;
            idle_cycles(1);
            clr_cmd_rdy = 1'b0;
            idle_cycles(2);
            check($sformatf("vec%0d_clr_rdy", v),  32'(cmd_rdy), 32'h0);
            check($sformatf("vec%0d_clr_cmd", v),  32'(cmd),     32'(vecs[v].e_cmd));
            check($sformatf("vec%0d_clr_data", v), 32'(data),    32'(vecs[v].e_data));
        end

        // Response 0xA5 with a second strobe mid-frame that must be ignored
        exp_bits = {1'b1, 8'hA5, 1'b0};
        @(posedge clk); #1;
        resp = 8'hA5; send_resp = 1'b1;
        @(posedge clk);
        pos = 0;
        #1;
        send_resp = 1'b0; resp = 8'h00;
        check("tx_start_low",    32'(tx),        32'h0);
        check("tx_sent_cleared", 32'(resp_sent), 32'h0);
        for (int k = 0; k < 10; k++) begin
            target = k * B + B / 2;
            while (pos < target) begin @(posedge clk); pos++; end
            #1;
            check($sformatf("tx_bit%0d", k), 32'(tx), 32'(exp_bits[k]));
            if (k == 3) begin
                send_resp = 1'b1;
                @(posedge clk); pos++;
                #1;
                send_resp = 1'b0;
            end
        end
        target = 10 * B - 1;
        while (pos < target) begin @(posedge clk); pos++; end
        #1;
        check("tx_sent_early", 32'(resp_sent), 32'h0);
        @(posedge clk); pos++;
        #1;
        check("tx_sent_done", 32'(resp_sent), 32'h1);
        check("tx_idle_high", 32'(tx),        32'h1);
        idle_cycles(12 * B);
        check("tx_no_second", 32'(tx),        32'h1);
        check("tx_sent_held", 32'(resp_sent), 32'h1);

        // Framing error discards the partial frame
        r0 = rises;
        send_byte(8'h02, 1'b1);
        send_byte(8'h55, 1'b0);
        idle_cycles(2 * B);
        send_byte(8'h07, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        idle_cycles(2 * B);
        check("ferr_cmd",   32'(cmd),        32'h07);
        check("ferr_data",  32'(data),       32'h0000);
        check("ferr_rises", 32'(rises - r0), 32'h1);

        // Long inter-byte gap
        send_byte(8'h02, 1'b1);
        idle_cycles(40 * B);
        send_byte(8'h03, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        idle_cycles(2 * B);
`ifdef FRAME_TIMEOUT_EN
        check("gap_cmd",     32'(cmd),     32'h03);
        check("gap_data",    32'(data),    32'h1234);
        check("gap_cmd_rdy", 32'(cmd_rdy), 32'h1);
`else
        check("gap_cmd",     32'(cmd),     32'h02);
        check("gap_data",    32'(data),    32'h0312);
        check("gap_cmd_rdy", 32'(cmd_rdy), 32'h0);
`endif

        // Reset in the middle of the second byte
        send_byte(8'h09, 1'b1);
        rx = 1'b0;
        idle_cycles(3 * B);
        rst_n = 1'b0;
        rx = 1'b1;
        idle_cycles(5);
        check("mid_rst_cmd",       32'(cmd),       32'h00);
        check("mid_rst_data",      32'(data),      32'h0000);
        check("mid_rst_cmd_rdy",   32'(cmd_rdy),   32'h0);
        check("mid_rst_resp_sent", 32'(resp_sent), 32'h0);
        check("mid_rst_tx",        32'(tx),        32'h1);
        rst_n = 1'b1;
        idle_cycles(5);

        // Clear held across the completing byte: the set must still occur
        r0 = rises;
        send_byte(8'h08, 1'b1);
        send_byte(8'h00, 1'b1);
        clr_cmd_rdy = 1'b1;
        send_byte(8'h00, 1'b1);
        idle_cycles(2 * B);
        check("post_rst_cmd",   32'(cmd),        32'h08);
        check("post_rst_data",  32'(data),       32'h0000);
        check("set_wins_rises", 32'(rises - r0), 32'h1);
        check("clr_after_set",  32'(cmd_rdy),    32'h0);
        clr_cmd_rdy = 1'b0;
        idle_cycles(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
